// File: rtl/hwpe_ctrl_useq.sv
// Microcode loop sequencer: walks up to NB_LOOPS nested loops, runs the per-loop
// offset-update microcode and emits one flags beat per iteration.

package hwpe_ctrl_useq_pkg;

    localparam int UCODE_NB_LOOPS       = 6;
    localparam int UCODE_LENGTH         = 16;
    localparam int UCODE_NB_REG         = 4;
    localparam int UCODE_REG_WIDTH      = 32;
    localparam int UCODE_CNT_WIDTH      = 12;
    localparam int UCODE_ADDR_WIDTH     = $clog2(UCODE_LENGTH);
    localparam int UCODE_OPS_WIDTH      = $clog2(UCODE_LENGTH + 1);
    localparam int UCODE_REG_ADDR_WIDTH = 5;
    localparam int UCODE_ACCUM_WIDTH    = $clog2(UCODE_NB_LOOPS + 1);

    typedef struct packed {
        logic                         enable;
        logic                         clear;
        logic [UCODE_ACCUM_WIDTH-1:0] accum_loop;
    } ctrl_ucode_t;

    typedef struct packed {
        logic                                                done;
        logic                                                valid;
        logic [UCODE_NB_REG-1:0][UCODE_REG_WIDTH-1:0]        offs;
        logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0]      idx;
        logic                                                accum;
    } flags_ucode_t;

    typedef struct packed {
        logic [UCODE_ADDR_WIDTH-1:0] ucode_addr;
        logic [UCODE_OPS_WIDTH-1:0]  nb_ops;
    } ucode_loop_t;

    typedef struct packed {
        logic                            op_sel;  // 1: ADD, 0: MOV
        logic [UCODE_REG_ADDR_WIDTH-1:0] a;
        logic [UCODE_REG_ADDR_WIDTH-1:0] b;
    } ucode_code_t;

    typedef struct packed {
        ucode_loop_t [UCODE_NB_LOOPS-1:0]                   loops;
        ucode_code_t [UCODE_LENGTH-1:0]                     code;
        logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0]     range;
    } ucode_t;

endpackage

module hwpe_ctrl_useq
    import hwpe_ctrl_useq_pkg::*;
#(
    parameter int NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int LENGTH    = UCODE_LENGTH,
    parameter int NB_REG    = UCODE_NB_REG,
    parameter int NB_RO_REG = 28,
    parameter int REG_WIDTH = UCODE_REG_WIDTH,
    parameter int CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  ctrl_ucode_t                          ctrl_i,
    output flags_ucode_t                         flags_o,
    input  ucode_t                               ucode_i,
    input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  registers_read_i
);

    localparam int LVL_WIDTH = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [NB_REG-1:0][REG_WIDTH-1:0]     offs_q, offs_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   range_eff;
    logic [UCODE_ADDR_WIDTH-1:0]          ptr_q, ptr_d;
    logic [UCODE_OPS_WIDTH-1:0]           cnt_q, cnt_d;
    logic                                 accum_q, accum_d;
    logic [NB_LOOPS-1:0]                  at_last;
    logic                                 carry_found;
    logic [LVL_WIDTH-1:0]                 carry_lvl;
    ucode_code_t                          op_cur;
    ucode_loop_t                          loop_cur;
    logic [REG_WIDTH-1:0]                 val_a, val_b, op_res;

    // Unified operand space: writable offsets, then the read-only bank, then zeros.
    function automatic logic [REG_WIDTH-1:0] read_reg(
        input logic [UCODE_REG_ADDR_WIDTH-1:0]  x,
        input logic [NB_REG-1:0][REG_WIDTH-1:0] offs,
        input logic [NB_RO_REG-1:0][REG_WIDTH-1:0] ro
    );
        logic [REG_WIDTH-1:0] val;
        val = '0;
        for (int r = 0; r < NB_REG; r++) begin
            if (x == UCODE_REG_ADDR_WIDTH'(r)) val = offs[r];
        end
        for (int r = 0; r < NB_RO_REG; r++) begin
            if (x == UCODE_REG_ADDR_WIDTH'(NB_REG + r)) val = ro[r];
        end
        return val;
    endfunction

    // Carry level: lowest loop whose counter has not reached its last value.
    always_comb begin
        carry_found = 1'b0;
        carry_lvl   = '0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            range_eff[l] = (ucode_i.range[l] == '0) ? CNT_WIDTH'(1) : ucode_i.range[l];
            at_last[l]   = (idx_q[l] == range_eff[l] - CNT_WIDTH'(1));
        end
        for (int l = NB_LOOPS - 1; l >= 0; l--) begin
            if (!at_last[l]) begin
                carry_found = 1'b1;
                carry_lvl   = LVL_WIDTH'(l);
            end
        end
    end

    assign loop_cur = ucode_i.loops[carry_lvl];
    assign op_cur   = ucode_i.code[ptr_q];
    assign val_a    = read_reg(op_cur.a, offs_q, registers_read_i);
    assign val_b    = read_reg(op_cur.b, offs_q, registers_read_i);
    assign op_res   = op_cur.op_sel ? (val_a + val_b) : val_b;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        offs_d  = offs_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        accum_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl_i.enable) state_d = VALID;
            end
            VALID: begin
                if (ctrl_i.enable) begin
                    if (!carry_found) begin
                        state_d = DONE;
                    end else begin
                        for (int l = 0; l < NB_LOOPS; l++) begin
                            if (l < int'(carry_lvl))       idx_d[l] = '0;
                            else if (l == int'(carry_lvl)) idx_d[l] = idx_q[l] + CNT_WIDTH'(1);
                        end
                        ptr_d   = loop_cur.ucode_addr;
                        cnt_d   = loop_cur.nb_ops;
                        state_d = (loop_cur.nb_ops == '0) ? VALID : EXEC;
                    end
                end
            end
            EXEC: begin
                for (int r = 0; r < NB_REG; r++) begin
                    if (op_cur.a == UCODE_REG_ADDR_WIDTH'(r)) offs_d[r] = op_res;
                end
                ptr_d = (ptr_q == UCODE_ADDR_WIDTH'(LENGTH - 1)) ? '0 : ptr_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= UCODE_OPS_WIDTH'(1)) state_d = VALID;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != IDLE) begin
            accum_d = 1'b1;
            for (int l = 0; l < NB_LOOPS; l++) begin
                if (l < int'(ctrl_i.accum_loop) && idx_d[l] != '0) accum_d = 1'b0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge. The offset register file is
    // small and must read as zero after clear, so it is reset like plain flops.
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            state_q <= IDLE;
            offs_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            accum_q <= 1'b0;
        end else begin
            state_q <= state_d;
            offs_q  <= offs_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            accum_q <= accum_d;
        end
    end

    always_comb begin
        flags_o       = '0;
        flags_o.done  = (state_q == DONE);
        flags_o.valid = (state_q == VALID);
        flags_o.offs  = offs_q;
        flags_o.idx   = idx_q;
        flags_o.accum = accum_q;
    end

endmodule

// File: doc/hwpe_ctrl_useq.md
Name: hwpe_ctrl_useq

Overview:
- Microcode loop sequencer. Consumes the `ucode_t` programme (loops, code, range) and the read-only register bank produced by the control regfile.
- Walks up to `NB_LOOPS` nested loops and executes the per-loop microcode ops that update the offset registers.
- Emits one `flags_ucode_t` beat per iteration to the streamer/address-generation stage downstream.
- Sits between `hwpe_ctrl_regfile`/`hwpe_ctrl_slave` (upstream) and the engine's source/sink streamers (downstream).

Parameters:
- `NB_LOOPS`, 6, number of nested loops; must equal `UCODE_NB_LOOPS`.
- `LENGTH`, 16, microcode op slots; must equal `UCODE_LENGTH`.
- `NB_REG`, 4, writable offset registers, addresses 0..`NB_REG`-1.
- `NB_RO_REG`, 28, read-only registers, addresses `NB_REG`..`NB_REG`+`NB_RO_REG`-1; `NB_REG`+`NB_RO_REG` must be ≤32.
- `REG_WIDTH`, 32, register width.
- `CNT_WIDTH`, 12, loop index/range width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `ctrl_i`  in  `ctrl_ucode_t`  enable (advance/ready), clear (soft reset), accum_loop.
- `flags_o`  out  `flags_ucode_t`  done, valid, offs[`NB_REG`], idx[`NB_LOOPS`], accum.
- `ucode_i`  in  `ucode_t`  loops[].{ucode_addr, nb_ops}, code[].{op_sel, a, b}, range[]; held stable while not in IDLE.
- `registers_read_i`  in  `NB_RO_REG`x`REG_WIDTH`  read-only operand bank.

Behaviour:
- **Reset / clear.** `rst_i`=1 or `ctrl_i.clear`=1 (same cycle, synchronous, clear wins over enable) forces:
  - state=IDLE;
  - all offs regs=0, all idx=0;
  - op pointer and op counter=0;
  - `flags_o`=0.
- **Registered outputs.** offs mirrors the writable regs, idx mirrors the loop counters, valid=(state==VALID), done=(state==DONE).
- **Effective range.** range[l]==0 is treated as 1. Loop l is "at last" when idx[l]==range_eff[l]-1.
- **Carry level.** L = lowest l with idx[l] not at last. "None" means the final iteration has been reached.
- **FSM states:** IDLE, VALID, EXEC, DONE.
  - **IDLE:** enable=1 -> VALID. This first beat carries idx=0 and offs=0, with no ops executed.
  - **VALID (ready/valid handshake):**
    - enable=0: hold; outputs stay stable with valid=1.
    - enable=1, no carry level: -> DONE.
    - enable=1, carry level L exists:
      - idx[L] increments; idx[0..L-1] go to 0 (all in the same cycle);
      - op pointer loads loops[L].ucode_addr and op counter loads loops[L].nb_ops;
      - next state is EXEC, or VALID directly if nb_ops==0.
  - **EXEC:** one op per cycle, independent of enable.
    - op_sel=1: ADD, R[a] = R[a] + R[b], modulo 2^32.
    - op_sel=0: MOV, R[a] = R[b].
    - Operand R[x]: x<`NB_REG` gives the offs reg; `NB_REG`≤x<`NB_REG`+`NB_RO_REG` gives registers_read_i[x-`NB_REG`]; any higher x reads 0.
    - Destination a≥`NB_REG`: the write is dropped silently.
    - Pointer increments and wraps modulo `LENGTH`. After the nb_ops-th op -> VALID.
  - **DONE:** done=1, valid=0; held until clear/reset. enable is ignored.
- **accum.** Registered; accum=1 iff idx[l]==0 for all l<accum_loop. accum_loop=0 gives accum=1 always.
- **Latency.** IDLE->first valid: 1 cycle. Each subsequent beat: 1+nb_ops[L] cycles after the accepting enable.
- **Iteration count.** Total beats = product of range_eff. The done cycle follows the acceptance of the last beat by one cycle.
- **Ops within one iteration.** Ops execute sequentially; a later op sees the results of earlier ops in the same iteration.

Test Plan:
- **Single loop, ADD.** range[0]=4, loops[0]={addr 0, nb_ops 1}, code[0]={ADD,a=0,b=4}, RO[0]=16, enable=1 -> 4 valid beats, offs[0]=0,16,32,48, idx[0]=0..3, then done=1 one cycle after the 4th beat.
- **Nested loops, MOV.** range[0]=3, range[1]=2; loops[0] op {ADD r0+=RO[0]=4}; loops[1] ops {MOV r0=RO[1]=0 (a=0,b=5), ADD r1+=RO[2]=100 (a=1,b=6)} -> 6 beats, (idx1,idx0) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), offs[0]=0,4,8,0,4,8, offs[1]=0,0,0,100,100,100, then done.
- **Backpressure.** Drop enable for 5 cycles while in VALID -> valid and offs stable for 5 cycles; raise enable -> next beat after 1+nb_ops cycles; no beat lost or duplicated.
- **Boundary.** range[0]=0 with all other ranges 0 -> exactly 1 beat then done. Also: an op with a=10 (RO address) leaves offs unchanged; nb_ops=0 gives back-to-back beats one cycle apart.
- **Clear/reset mid-operation.** Assert ctrl_i.clear while in EXEC -> next cycle all outputs 0, state IDLE; the restarted sequence reproduces the first scenario exactly. The same holds with rst_i asserted, and with clear and enable both high in the same cycle.
- **accum.** accum_loop=1 with the nested setup -> accum=1 exactly on beats with idx0=0 (beats 1 and 4).
